// File: rtl/serial_link_chan_arb.sv
// Round-robin scheduler of the AW/W/AR/R streams onto the single link send path, with tag
// insertion and credit flow control. Optional W burst lock: SERIAL_LINK_ARB_W_BURST_LOCK_EN.

package serial_link_pkg;
    localparam int unsigned NumCredits  = 10;
    localparam int unsigned CreditWidth = $clog2(NumCredits + 1);

    typedef logic [CreditWidth-1:0] credit_t;

    typedef enum logic [3:0] {
        TagIdle = 4'd0,
        TagAW   = 4'd1,
        TagW    = 4'd2,
        TagAR   = 4'd3,
        TagR    = 4'd4
    } tag_e;

    typedef enum logic {
        LinkSendIdle,
        LinkSendBusy
    } link_state_e;
endpackage

module serial_link_chan_arb #(
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned NumCredits = serial_link_pkg::NumCredits
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      en_i,
    input  logic [3:0]                req_valid_i,
    output logic [3:0]                req_ready_o,
    input  logic [4*DataWidth-1:0]    req_data_i,
    input  logic                      w_last_i,
    output logic                      link_valid_o,
    input  logic                      link_ready_i,
    output serial_link_pkg::tag_e     link_tag_o,
    output logic [DataWidth-1:0]      link_data_o,
    input  logic                      credits_ret_valid_i,
    input  serial_link_pkg::credit_t  credits_ret_i,
    output serial_link_pkg::credit_t  credits_o,
    output logic                      credit_err_o
);
    localparam int unsigned CW = serial_link_pkg::CreditWidth;
    localparam logic [CW:0] MaxCred = (CW + 1)'(NumCredits);

    serial_link_pkg::link_state_e state_q;
    serial_link_pkg::tag_e        tag_q;
    logic [DataWidth-1:0]         data_q;
    serial_link_pkg::credit_t     credits_q;
    logic                         credit_err_q;
    logic [1:0]                   rr_q;

    logic       slot_free;
    logic       grant_ok;
    logic       grant;
    logic       found;
    logic [1:0] winner;
    logic [3:0] cand;
    logic [CW:0] cred_sum;
    logic        cred_ovf;

`ifdef SERIAL_LINK_ARB_W_BURST_LOCK_EN
    logic lock_q;
    // While a W burst is open only the W stream may compete.
    assign cand = lock_q ? (req_valid_i & 4'b0010) : req_valid_i;
`else
    logic unused_w_last;
    assign unused_w_last = w_last_i;
    assign cand = req_valid_i;
`endif

    assign link_valid_o = (state_q == serial_link_pkg::LinkSendBusy);
    assign slot_free    = !link_valid_o || link_ready_i;
    assign grant_ok     = en_i && slot_free && (credits_q != '0);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        logic [1:0] idx;
        found  = 1'b0;
        winner = 2'd0;
        idx    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_q + 2'(i);
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign grant       = grant_ok && found;
    assign req_ready_o = grant ? (4'b0001 << winner) : 4'b0000;

    always_comb begin
        cred_sum = {1'b0, credits_q} - {{CW{1'b0}}, grant};
        if (credits_ret_valid_i) begin
            cred_sum = cred_sum + {1'b0, credits_ret_i};
        end
        cred_ovf = (cred_sum > MaxCred);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= serial_link_pkg::LinkSendIdle;
            tag_q        <= serial_link_pkg::TagIdle;
            data_q       <= '0;
            credits_q    <= serial_link_pkg::credit_t'(NumCredits);
            credit_err_q <= 1'b0;
            rr_q         <= 2'd0;
        end else begin
            case (state_q)
                serial_link_pkg::LinkSendIdle: begin
                    if (grant) begin
                        state_q <= serial_link_pkg::LinkSendBusy;
                        tag_q   <= serial_link_pkg::tag_e'({2'b00, winner} + 4'd1);
                        data_q  <= req_data_i[winner*DataWidth +: DataWidth];
                    end
                end
                serial_link_pkg::LinkSendBusy: begin
                    if (grant) begin
                        tag_q  <= serial_link_pkg::tag_e'({2'b00, winner} + 4'd1);
                        data_q <= req_data_i[winner*DataWidth +: DataWidth];
                    end else if (link_ready_i) begin
                        state_q <= serial_link_pkg::LinkSendIdle;
                        tag_q   <= serial_link_pkg::TagIdle;
                    end
                end
                default: state_q <= serial_link_pkg::LinkSendIdle;
            endcase

            if (grant) begin
                rr_q <= winner + 2'd1;
            end

            if (cred_ovf) begin
                credits_q    <= serial_link_pkg::credit_t'(NumCredits);
                credit_err_q <= 1'b1;
            end else begin
                credits_q <= cred_sum[CW-1:0];
            end
        end
    end

`ifdef SERIAL_LINK_ARB_W_BURST_LOCK_EN
    // The pointer already lands on AR (winner+1) when the closing W beat is granted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= 1'b0;
        end else if (grant && (winner == 2'd1)) begin
            lock_q <= !w_last_i;
        end
    end
`endif

    assign link_tag_o   = tag_q;
    assign link_data_o  = data_q;
    assign credits_o    = credits_q;
    assign credit_err_o = credit_err_q;

endmodule

// File: tb/tb_serial_link_chan_arb.sv
// Self-checking bench for serial_link_chan_arb: directed steps plus random traffic against a
// behavioural model of the scheduling, credit and hold rules.

module tb_serial_link_chan_arb;
    localparam int DW = 64;
    localparam int NC = 10;

    logic                     clk_i = 1'b0;
    logic                     rst_ni;
    logic                     en_i;
    logic [3:0]               req_valid_i;
    logic [3:0]               req_ready_o;
    logic [4*DW-1:0]          req_data_i;
    logic                     w_last_i;
    logic                     link_valid_o;
    logic                     link_ready_i;
    serial_link_pkg::tag_e    link_tag_o;
    logic [DW-1:0]            link_data_o;
    logic                     credits_ret_valid_i;
    serial_link_pkg::credit_t credits_ret_i;
    serial_link_pkg::credit_t credits_o;
    logic                     credit_err_o;

    logic [DW-1:0] dat [4];
    assign req_data_i = {dat[3], dat[2], dat[1], dat[0]};

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          m_valid;
    int          m_tag;
    logic [DW-1:0] m_data;
    int          m_cred;
    bit          m_err;
    int          m_rr;
    bit          m_lock;

    serial_link_chan_arb #(.DataWidth(DW), .NumCredits(NC)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .en_i               (en_i),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_data_i         (req_data_i),
        .w_last_i           (w_last_i),
        .link_valid_o       (link_valid_o),
        .link_ready_i       (link_ready_i),
        .link_tag_o         (link_tag_o),
        .link_data_o        (link_data_o),
        .credits_ret_valid_i(credits_ret_valid_i),
        .credits_ret_i      (credits_ret_i),
        .credits_o          (credits_o),
        .credit_err_o       (credit_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_tag = 0; m_data = '0; m_cred = NC; m_err = 0; m_rr = 0; m_lock = 0;
    endtask

    // First requesting stream at or after the pointer; an open W burst admits only W.
    function automatic int model_winner();
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (m_rr + i) % 4;
            if (m_lock && k != 1) continue;
            if (req_valid_i[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready();
        int w;
        if (en_i && (!m_valid || link_ready_i) && m_cred > 0) begin
            w = model_winner();
            if (w >= 0) return 4'(1 << w);
        end
        return 4'b0000;
    endfunction

    task automatic model_clock(input logic [3:0] rdy);
        int w;
        int c;
        w = -1;
        for (int i = 0; i < 4; i++) if (rdy[i]) w = i;
        if (w >= 0) begin
            m_valid = 1; m_tag = w + 1; m_data = dat[w];
            m_rr = (w + 1) % 4;
`ifdef SERIAL_LINK_ARB_W_BURST_LOCK_EN
            if (w == 1) m_lock = !w_last_i;
`endif
        end else if (link_ready_i) begin
            m_valid = 0; m_tag = 0;
        end
        c = m_cred - ((w >= 0) ? 1 : 0) + (credits_ret_valid_i ? int'(credits_ret_i) : 0);
        if (c > NC) begin
            c = NC; m_err = 1;
        end
        m_cred = c;
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic step();
        logic [3:0] er;
        #1;
        er = model_ready();
        check("req_ready", req_ready_o, er);
        @(posedge clk_i);
        model_clock(er);
        @(negedge clk_i);
        check("link_valid", link_valid_o, m_valid);
        check("link_tag", link_tag_o, m_tag);
        if (m_valid) check("link_data", link_data_o, m_data);
        check("credits", credits_o, m_cred);
        check("credit_err", credit_err_o, m_err);
    endtask

    task automatic rand_data();
        for (int i = 0; i < 4; i++) dat[i] = {$urandom, $urandom};
    endtask

    initial begin
        logic [3:0] tag_seq [5];
        logic [DW-1:0] held;
        tag_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};

        rst_ni = 0; en_i = 0; req_valid_i = 0; w_last_i = 1; link_ready_i = 0;
        credits_ret_valid_i = 0; credits_ret_i = '0;
        rand_data();
        model_reset();

        // Reset values
        #12;
        check("rst_valid", link_valid_o, 1'b0);
        check("rst_tag", link_tag_o, 4'd0);
        check("rst_data", link_data_o, 64'd0);
        check("rst_credits", credits_o, 4'd10);
        check("rst_err", credit_err_o, 1'b0);
        check("rst_ready", req_ready_o, 4'd0);
        @(negedge clk_i);
        rst_ni = 1;

        // All four streams valid, full throughput; one credit back per packet
        en_i = 1; req_valid_i = 4'b1111; link_ready_i = 1;
        credits_ret_valid_i = 1; credits_ret_i = 4'd1;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            step();
            check("rr_tag_seq", link_tag_o, tag_seq[i]);
        end

        // Drain every credit with AR only
        req_valid_i = 4'b0100; credits_ret_valid_i = 0;
        for (int i = 0; i < NC; i++) begin
            rand_data();
            step();
        end
        #1;
        check("drained_credits", credits_o, 4'd0);
        check("drained_ready", req_ready_o, 4'd0);
        step();
        credits_ret_valid_i = 1; credits_ret_i = 4'd1;
        step();
        credits_ret_valid_i = 0;
        #1;
        check("regrant_ready", req_ready_o, 4'b0100);
        step();
        check("regrant_tag", link_tag_o, 4'd3);

        // Consume and return in the same cycle, then overflow
        req_valid_i = 4'b0000; credits_ret_valid_i = 1; credits_ret_i = 4'd5;
        step();
        check("cred_five", credits_o, 4'd5);
        req_valid_i = 4'b0100; credits_ret_i = 4'd3;
        step();
        check("cred_seven", credits_o, 4'd7);
        req_valid_i = 4'b0000;
        step();
        check("cred_ten", credits_o, 4'd10);
        credits_ret_i = 4'd2;
        step();
        check("cred_clamp", credits_o, 4'd10);
        check("cred_err_set", credit_err_o, 1'b1);
        credits_ret_valid_i = 0;

        // Backpressure: held packet stays stable, then releases with a same-cycle grant
        req_valid_i = 4'b1111; link_ready_i = 0;
        rand_data();
        step();
        held = link_data_o;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            step();
            check("hold_data", link_data_o, held);
        end
        link_ready_i = 1;
        #1;
        check("release_grant", (req_ready_o != 4'd0), 1'b1);
        step();

        // Disable mid-packet: held packet completes, nothing new, credits still return
        link_ready_i = 0;
        step();
        en_i = 0;
        step();
        link_ready_i = 1; credits_ret_valid_i = 1; credits_ret_i = 4'd1;
        step();
        check("disable_idle", link_valid_o, 1'b0);
        step();
        credits_ret_valid_i = 0; en_i = 1;

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            rand_data();
            req_valid_i         = 4'($urandom);
            en_i                = ($urandom_range(0, 7) != 0);
            link_ready_i        = ($urandom_range(0, 3) != 0);
            w_last_i            = ($urandom_range(0, 2) == 0);
            credits_ret_valid_i = ($urandom_range(0, 2) == 0);
            credits_ret_i       = serial_link_pkg::credit_t'($urandom_range(0, 3));
            step();
        end

        // Async reset in the middle of a held transfer
        req_valid_i = 4'b1111; en_i = 1; link_ready_i = 0; w_last_i = 1;
        step();
        #2 rst_ni = 0;
        #1;
        model_reset();
        check("arst_valid", link_valid_o, 1'b0);
        check("arst_tag", link_tag_o, 4'd0);
        check("arst_credits", credits_o, 4'd10);
        check("arst_err", credit_err_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1; link_ready_i = 1; req_valid_i = 4'b0000;
        credits_ret_valid_i = 0;
        step();

`ifdef SERIAL_LINK_ARB_W_BURST_LOCK_EN
        // W burst of three beats holds off AW and AR, then RR resumes at AR
        req_valid_i = 4'b0010; w_last_i = 0;
        step();
        check("lock_b1", link_tag_o, 4'd2);
        req_valid_i = 4'b0111;
        step();
        check("lock_b2", link_tag_o, 4'd2);
        w_last_i = 1;
        step();
        check("lock_b3", link_tag_o, 4'd2);
        req_valid_i = 4'b0101;
        step();
        check("lock_ar", link_tag_o, 4'd3);
        step();
        check("lock_aw", link_tag_o, 4'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
